// File: rtl/mem_access_ctrl.sv
// Grant / MAR-load / timed access / ack sequencer sharing the SAP MAR and RAM port.
// Define MAC_RR_ARB_EN for round-robin arbitration; otherwise data beats fetch.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        data_req,
    input  logic [15:0] data_addr,
    input  logic        data_we,
    input  logic [15:0] data_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mar_write,
    output logic [15:0] mar_bus,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    output logic        fetch_ack,
    output logic        data_ack,
    output logic [15:0] rdata,
    output logic        busy
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_access_ctrl: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
    end

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        id_data_q, id_data_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        grant_data;

`ifdef MAC_RR_ARB_EN
    // 1 = data was granted last; reset value means fetch-last.
    logic last_data_q, last_data_d;

    always_comb begin
        grant_data = data_req & (~fetch_req | ~last_data_q);
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    always_comb begin
        state_d   = state_q;
        id_data_d = id_data_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
`ifdef MAC_RR_ARB_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    id_data_d = grant_data;
                    addr_d    = grant_data ? data_addr : fetch_addr;
                    we_d      = grant_data & data_we;
                    wdata_d   = grant_data ? data_wdata : 16'h0000;
                    state_d   = LOAD;
`ifdef MAC_RR_ARB_EN
                    last_data_d = grant_data;
`endif
                end
            end
            LOAD: begin
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            id_data_q <= 1'b0;
            addr_q    <= 16'h0000;
            we_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            cnt_q     <= 4'd0;
            rdata_q   <= 16'h0000;
`ifdef MAC_RR_ARB_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            id_data_q <= id_data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
`ifdef MAC_RR_ARB_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // Outputs decode only from state and latched registers.
    assign mar_write = (state_q == LOAD);
    assign mar_bus   = mar_write ? addr_q : 16'h0000;
    assign mem_rd    = (state_q == ACCESS) & ~we_q;
    assign mem_wr    = (state_q == ACCESS) & we_q;
    assign mem_wdata = mem_wr ? wdata_q : 16'h0000;
    assign fetch_ack = (state_q == DONE) & ~id_data_q;
    assign data_ack  = (state_q == DONE) & id_data_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=2; expectations hand-computed.
module tb_mem_access_ctrl;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr, data_wdata, mem_rdata;
    logic        mar_write, mem_rd, mem_wr, fetch_ack, data_ack, busy;
    logic [15:0] mar_bus, mem_wdata, rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .data_req(data_req), .data_addr(data_addr),
        .data_we(data_we), .data_wdata(data_wdata),
        .mem_rdata(mem_rdata),
        .mar_write(mar_write), .mar_bus(mar_bus),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .fetch_ack(fetch_ack), .data_ack(data_ack),
        .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs the control outputs: {mar_write, mem_rd, mem_wr, fetch_ack, data_ack, busy}
    function automatic logic [15:0] ctl();
        return {10'd0, mar_write, mem_rd, mem_wr, fetch_ack, data_ack, busy};
    endfunction

    logic [15:0] first_addr, second_addr;
    logic        first_is_data;

    initial begin
        rst = 1'b1;
        fetch_req = 0; data_req = 0; data_we = 0;
        fetch_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
        #2;
        chk("reset_ctl", ctl(), 16'h0000);
        chk("reset_rdata", rdata, 16'h0000);
        step(); step();
        rst = 1'b0;
        step();
        chk("idle_after_reset", ctl(), 16'h0000);

        // Single fetch
        fetch_req = 1; fetch_addr = 16'h0123; mem_rdata = 16'hBEEF;
        step();
        chk("fetch_load_ctl", ctl(), 16'b100001);
        chk("fetch_mar_bus", mar_bus, 16'h0123);
        step();
        chk("fetch_acc1_ctl", ctl(), 16'b010001);
        step();
        chk("fetch_acc2_ctl", ctl(), 16'b010001);
        step();
        chk("fetch_done_ctl", ctl(), 16'b000101);
        chk("fetch_rdata", rdata, 16'hBEEF);
        fetch_req = 0;
        step();
        chk("fetch_idle_ctl", ctl(), 16'h0000);

        // Data write plus input stability after grant
        data_req = 1; data_we = 1; data_addr = 16'h00F0; data_wdata = 16'h5A5A;
        mem_rdata = 16'h1111;
        step();
        data_addr = 16'hFFFF; data_wdata = 16'h0000; data_we = 0;
        #1;
        chk("wr_load_ctl", ctl(), 16'b100001);
        chk("wr_mar_stable", mar_bus, 16'h00F0);
        step();
        chk("wr_acc1_ctl", ctl(), 16'b001001);
        chk("wr_wdata1", mem_wdata, 16'h5A5A);
        step();
        chk("wr_acc2_ctl", ctl(), 16'b001001);
        chk("wr_wdata2", mem_wdata, 16'h5A5A);
        step();
        chk("wr_done_ctl", ctl(), 16'b000011);
        chk("wr_rdata_kept", rdata, 16'hBEEF);
        chk("wr_wdata_off", mem_wdata, 16'h0000);
        data_req = 0;
        step();
        chk("wr_idle_ctl", ctl(), 16'h0000);

        // Contention; last grant was data
        fetch_req = 1; fetch_addr = 16'h0200;
        data_req = 1; data_addr = 16'h0300; data_we = 0; mem_rdata = 16'hCAFE;
`ifdef MAC_RR_ARB_EN
        first_is_data = 0; first_addr = 16'h0200; second_addr = 16'h0300;
`else
        first_is_data = 1; first_addr = 16'h0300; second_addr = 16'h0200;
`endif
        step();
        chk("cont1_mar_bus", mar_bus, first_addr);
        step(); step(); step();
        chk("cont1_ack", ctl(), first_is_data ? 16'b000011 : 16'b000101);
        chk("cont1_rdata", rdata, 16'hCAFE);
        if (first_is_data) data_req = 0; else fetch_req = 0;
        mem_rdata = 16'hD00D;
        step();
        chk("cont_gap_idle", ctl(), 16'h0000);
        step();
        chk("cont2_mar_bus", mar_bus, second_addr);
        step(); step(); step();
        chk("cont2_ack", ctl(), first_is_data ? 16'b000101 : 16'b000011);
        chk("cont2_rdata", rdata, 16'hD00D);
        fetch_req = 0; data_req = 0;
        step();
        chk("cont_end_idle", ctl(), 16'h0000);

        // Request dropped during ACCESS
        fetch_req = 1; fetch_addr = 16'h0400; mem_rdata = 16'h7777;
        step(); step();
        fetch_req = 0;
        step(); step();
        chk("drop_ack", ctl(), 16'b000101);
        chk("drop_rdata", rdata, 16'h7777);
        step();
        chk("drop_idle", ctl(), 16'h0000);

        // Async reset in the middle of ACCESS
        fetch_req = 1; fetch_addr = 16'h0555; mem_rdata = 16'h9999;
        step(); step();
        chk("rst_pre_acc", ctl(), 16'b010001);
        fetch_req = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctl", ctl(), 16'h0000);
        chk("rst_async_rdata", rdata, 16'h0000);
        chk("rst_async_mar", mar_bus, 16'h0000);
        step(); step();
        chk("rst_held_ctl", ctl(), 16'h0000);
        rst = 1'b0;
        step(); step();
        chk("rst_release_idle", ctl(), 16'h0000);
        chk("rst_release_rdata", rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer and arbiter for the 16-bit SAP memory address path. It shares the memory address register and RAM port between two requesters: the instruction-fetch path and the operand/data path. For each access it runs a fixed sequence: grant, MAR load, timed memory access, acknowledge. It sits between the control unit's requesters and the MAR/RAM pair on the system bus.

## Interface
- WAIT_CYCLES, 1, cycles mem_rd/mem_wr stay asserted per access; legal range 1..15.
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  fetch access request; level, held until fetch_ack.
- fetch_addr  in  16  fetch address (PC value).
- data_req  in  1  data access request; level, held until data_ack.
- data_addr  in  16  operand address.
- data_we  in  1  1 = write, 0 = read (data requester only; fetch is always a read).
- data_wdata  in  16  write data.
- mem_rdata  in  16  RAM read data at the MAR address.
- mar_write  out  1  load strobe to the MAR.
- mar_bus  out  16  value the MAR loads when mar_write=1.
- mem_rd  out  1  RAM read enable.
- mem_wr  out  1  RAM write enable.
- mem_wdata  out  16  RAM write data.
- fetch_ack  out  1  one-cycle completion pulse to the fetch requester.
- data_ack  out  1  one-cycle completion pulse to the data requester.
- rdata  out  16  captured read data; valid with the ack and held until the next capture.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ACCESS, DONE.
- **IDLE.** If any request is high, the block:
  - arbitrates;
  - registers the winner's ID, address, we and wdata;
  - moves to LOAD.
  - With no request it stays in IDLE.
- **LOAD.** Lasts 1 cycle. mar_write=1 and mar_bus=latched address. Next state is ACCESS, with the wait counter set to WAIT_CYCLES-1.
- **ACCESS.**
  - mem_rd=~we or mem_wr=we. mem_wdata=latched wdata while mem_wr=1, otherwise 0.
  - The counter decrements each cycle. When it reaches 0, the block moves to DONE.
  - On that final edge, rdata <= mem_rdata for reads. rdata is unchanged for writes.
- **DONE.** Lasts 1 cycle. The winner's ack=1. Next state is always IDLE.
- **Arbitration (default).** Fixed priority: data_req beats fetch_req.
- **Latched values.** Request inputs are latched at grant. Changes to addr, wdata or we after grant are ignored.
- **Requester rules.**
  - A requester deasserts req in the cycle after its ack. If req is still high in IDLE, it counts as a new request.
  - A req dropped mid-transaction does not abort the access. The ack still pulses.
- **Simultaneous events.** Both requests high in IDLE: one is granted. The loser stays pending and is granted at the next IDLE.
- **Invalid parameter.** WAIT_CYCLES=0 is illegal. Simulation flags it with $error at elaboration.

## Timing
- Reset (async assert) forces the following immediately, with no ack and no partial access:
  - state=IDLE;
  - mar_write, mar_bus, mem_rd, mem_wr, mem_wdata, fetch_ack, data_ack, busy = 0;
  - rdata=0, counter=0, round-robin pointer=fetch-last.
- Reset deassertion takes effect at the next clk edge.
- Request sampled high in IDLE at cycle N:
  - LOAD in cycle N+1; the MAR holds the address from the edge ending N+1.
  - ACCESS in cycles N+2 .. N+1+WAIT_CYCLES.
  - DONE/ack in cycle N+2+WAIT_CYCLES.
- Request-to-ack latency is WAIT_CYCLES+2 cycles. Minimum spacing between grants is WAIT_CYCLES+3 cycles.
- All outputs are registered, or decoded only from state and latched registers. No input-to-output combinational paths.
- mem_rdata must be valid by the last ACCESS edge. The RAM has WAIT_CYCLES cycles of access time after the MAR update.

## Configuration
- MAC_RR_ARB_EN defined: round-robin arbitration.
  - On simultaneous requests, the requester not granted last wins.
  - A 1-bit pointer updates at each grant.
  - A single requester is always granted.
- MAC_RR_ARB_EN undefined: fixed data-over-fetch priority. The pointer logic is absent.

## Test plan
- **Reset.** Assert rst mid-ACCESS (WAIT_CYCLES=3) -> all outputs 0 immediately, no ack. After release with no req -> stays IDLE, busy=0.
- **Single fetch.** fetch_req=1, fetch_addr=16'h0123, mem_rdata=16'hBEEF, WAIT_CYCLES=2:
  - mar_write=1 with mar_bus=16'h0123 one cycle after the request;
  - mem_rd high for 2 cycles;
  - fetch_ack on cycle +4 with rdata=16'hBEEF.
- **Data write.** data_req=1, data_we=1, data_addr=16'h00F0, data_wdata=16'h5A5A -> mem_wr high WAIT_CYCLES cycles with mem_wdata=16'h5A5A, mem_rd never high, rdata unchanged, data_ack pulses once.
- **Contention.** fetch_req and data_req rise in the same cycle:
  - default build: data served first, fetch served next.
  - MAC_RR_ARB_EN build, after a prior data grant: fetch served first.
- **Input stability.** Change data_addr to 16'hFFFF the cycle after grant -> MAR still loads the original address.
- **Dropped request.** Drop req in ACCESS -> ack still pulses, then IDLE.
